// File: rtl/bill_validator.sv
// bill_validator: synchronises the bill-acceptor sensor, measures each high
// pulse and turns it into a single insert_bill strobe, a reject strobe, or a
// sticky jam indication. A low-time holdoff separates consecutive bills.
module bill_validator #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_W       = 8,
  parameter int unsigned MAX_W       = 64,
  parameter int unsigned GAP         = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic bill_raw,
  input  logic enable,
  input  logic jam_clr,
  output logic insert_bill,
  output logic reject,
  output logic busy,
  output logic jam
);

  localparam logic [CNT_W-1:0] L_MIN_W = CNT_W'(MIN_W);
  localparam logic [CNT_W-1:0] L_MAX_W = CNT_W'(MAX_W);
  localparam logic [CNT_W-1:0] L_JAM_W = CNT_W'(MAX_W + 1);
  localparam logic [CNT_W-1:0] L_GAP   = CNT_W'(GAP);
  localparam logic [CNT_W-1:0] L_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_HOLDOFF = 2'd2,
    ST_JAM     = 2'd3
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_wcnt;
  logic [CNT_W-1:0]       r_gcnt;
  logic                   r_insert;
  logic                   r_reject;
  logic                   r_jam;

  logic                   w_s;
  logic [CNT_W-1:0]       w_gcnt_inc;
  logic                   w_width_ok;

  assign w_s        = r_sync[SYNC_STAGES-1];
  assign w_gcnt_inc = (r_gcnt < L_GAP) ? (r_gcnt + L_ONE) : r_gcnt;
  assign w_width_ok = (r_wcnt >= L_MIN_W) && (r_wcnt <= L_MAX_W);

  // Multi-flop synchroniser for the asynchronous sensor line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bill_raw};
    end
  end

  // Pulse-measurement FSM with registered strobes and sticky jam flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_HOLDOFF;
      r_wcnt   <= '0;
      r_gcnt   <= '0;
      r_insert <= 1'b0;
      r_reject <= 1'b0;
      r_jam    <= 1'b0;
    end else begin
      r_insert <= 1'b0;
      r_reject <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_s) begin
            r_wcnt  <= L_ONE;
            r_state <= ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (w_s) begin
            if (r_wcnt == L_MAX_W) begin
              r_state  <= ST_JAM;
              r_reject <= 1'b1;
              r_jam    <= 1'b1;
            end else if (r_wcnt < L_JAM_W) begin
              r_wcnt <= r_wcnt + L_ONE;
            end
          end else begin
            if (w_width_ok && enable) begin
              r_insert <= 1'b1;
            end else begin
              r_reject <= 1'b1;
            end
            r_gcnt  <= '0;
            r_state <= ST_HOLDOFF;
          end
        end
        ST_HOLDOFF: begin
          if (w_s) begin
            r_gcnt <= '0;
          end else begin
            r_gcnt <= w_gcnt_inc;
            if (w_gcnt_inc == L_GAP) begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_JAM: begin
          if (!w_s && jam_clr) begin
            r_jam   <= 1'b0;
            r_gcnt  <= '0;
            r_state <= ST_HOLDOFF;
          end
        end
        default: begin
          r_state <= ST_HOLDOFF;
        end
      endcase
    end
  end

  assign insert_bill = r_insert;
  assign reject      = r_reject;
  assign jam         = r_jam;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_bill_validator.sv
// Bench for bill_validator: a pulse-level reference model checked every
// cycle, plus directed scenarios with hand-computed counts and latencies.
module tb_bill_validator;

  localparam int SYNC_STAGES = 2;
  localparam int MIN_W       = 8;
  localparam int MAX_W       = 64;
  localparam int GAP         = 16;
  localparam int CNT_W       = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bill_raw = 1'b0;
  logic enable = 1'b1;
  logic jam_clr = 1'b0;
  logic insert_bill, reject, busy, jam;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  int ins_cnt = 0;
  int rej_cnt = 0;
  int last_ins_cyc  = -1;
  int last_rej_cyc  = -1;
  int last_jam_rise = -1;
  int last_idle_cyc = -1;
  bit prev_busy = 1'b1;
  bit prev_jam  = 1'b0;

  // reference model state: pulse lengths and quiet-time counts
  logic [SYNC_STAGES-1:0] m_sync = '0;
  bit m_s      = 1'b0;
  bit m_armed  = 1'b0;
  bit m_jammed = 1'b0;
  int m_hi     = 0;
  int m_quiet  = 0;
  bit e_ins    = 1'b0;
  bit e_rej    = 1'b0;

  always #5 clk = ~clk;

  bill_validator #(
    .SYNC_STAGES(SYNC_STAGES),
    .MIN_W(MIN_W),
    .MAX_W(MAX_W),
    .GAP(GAP),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bill_raw(bill_raw),
    .enable(enable),
    .jam_clr(jam_clr),
    .insert_bill(insert_bill),
    .reject(reject),
    .busy(busy),
    .jam(jam)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc++;

  // Reference model and per-cycle comparison of all outputs.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sync = '0; m_armed = 1'b0; m_jammed = 1'b0;
      m_hi = 0; m_quiet = 0; e_ins = 1'b0; e_rej = 1'b0;
      #1;
      check("rst_insert_bill", insert_bill, 0);
      check("rst_reject", reject, 0);
      check("rst_busy", busy, 1);
      check("rst_jam", jam, 0);
      prev_busy = 1'b1;
      prev_jam  = 1'b0;
    end else begin
      m_s    = m_sync[SYNC_STAGES-1];
      m_sync = {m_sync[SYNC_STAGES-2:0], bill_raw};
      e_ins  = 1'b0;
      e_rej  = 1'b0;
      if (m_jammed) begin
        if (!m_s && jam_clr) begin
          m_jammed = 1'b0;
          m_quiet  = 0;
        end
      end else if (m_hi > 0) begin
        if (m_s) begin
          m_hi++;
          if (m_hi > MAX_W) begin
            e_rej = 1'b1; m_jammed = 1'b1; m_hi = 0;
          end
        end else begin
          if (m_hi >= MIN_W && m_hi <= MAX_W && enable) e_ins = 1'b1;
          else e_rej = 1'b1;
          m_hi = 0;
          m_quiet = 0;
        end
      end else if (m_armed) begin
        if (m_s) begin
          m_hi = 1;
          m_armed = 1'b0;
        end
      end else begin
        m_quiet = m_s ? 0 : m_quiet + 1;
        if (m_quiet == GAP) begin
          m_armed = 1'b1;
          m_quiet = 0;
        end
      end
      #1;
      check("insert_bill", insert_bill, e_ins);
      check("reject", reject, e_rej);
      check("busy", busy, !m_armed);
      check("jam", jam, m_jammed);
      check("strobe_exclusive", insert_bill & reject, 0);
      if (insert_bill) begin ins_cnt++; last_ins_cyc = cyc; end
      if (reject)      begin rej_cnt++; last_rej_cyc = cyc; end
      if (jam && !prev_jam) last_jam_rise = cyc;
      if (prev_busy && !busy) last_idle_cyc = cyc;
      prev_jam  = jam;
      prev_busy = busy;
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int w);
    bill_raw = 1'b1;
    wait_n(w);
    bill_raw = 1'b0;
  endtask

  initial begin
    int i0, r0, fall, rise, c0;
    int widths [3];
    int exp_ins [3];
    widths  = '{7, 8, 64};
    exp_ins = '{0, 1, 1};

    // reset, then GAP low samples before arming
    wait_n(3);
    check("lit_rst_busy", busy, 1);
    rst = 1'b0;
    wait_n(14);
    check("lit_holdoff_busy_14", busy, 1);
    wait_n(3);
    check("lit_armed_busy_17", busy, 0);

    // valid 20-cycle bill
    i0 = ins_cnt; r0 = rej_cnt;
    pulse(20); fall = cyc;
    wait_n(30);
    check("lit_valid_ins", ins_cnt - i0, 1);
    check("lit_valid_rej", rej_cnt - r0, 0);
    check("lit_valid_latency", last_ins_cyc - fall, 3);
    check("lit_valid_idle", last_idle_cyc - fall, 19);

    // width boundaries
    for (int k = 0; k < 3; k++) begin
      i0 = ins_cnt; r0 = rej_cnt;
      pulse(widths[k]);
      wait_n(30);
      check("lit_width_ins", ins_cnt - i0, exp_ins[k]);
      check("lit_width_rej", rej_cnt - r0, 1 - exp_ins[k]);
    end

    // disabled at the decision edge
    i0 = ins_cnt; r0 = rej_cnt;
    enable = 1'b0;
    pulse(20);
    wait_n(30);
    enable = 1'b1;
    check("lit_disabled_ins", ins_cnt - i0, 0);
    check("lit_disabled_rej", rej_cnt - r0, 1);

    // enable low during measurement but high at the decision
    i0 = ins_cnt; r0 = rej_cnt;
    enable = 1'b0;
    bill_raw = 1'b1;
    wait_n(10);
    enable = 1'b1;
    wait_n(10);
    bill_raw = 1'b0;
    wait_n(30);
    check("lit_late_enable_ins", ins_cnt - i0, 1);
    check("lit_late_enable_rej", rej_cnt - r0, 0);

    // jam: held high 100 cycles, clear attempted while high
    i0 = ins_cnt; r0 = rej_cnt;
    rise = cyc;
    bill_raw = 1'b1;
    wait_n(90);
    jam_clr = 1'b1;
    wait_n(1);
    jam_clr = 1'b0;
    wait_n(9);
    check("lit_jam_held", jam, 1);
    check("lit_jam_rise", last_jam_rise - rise, 67);
    check("lit_jam_reject_edge", last_rej_cyc - rise, 67);
    check("lit_jam_rej", rej_cnt - r0, 1);
    check("lit_jam_ins", ins_cnt - i0, 0);
    bill_raw = 1'b0;
    wait_n(5);
    check("lit_jam_still", jam, 1);
    jam_clr = 1'b1;
    wait_n(1);
    jam_clr = 1'b0;
    c0 = cyc;
    check("lit_jam_cleared", jam, 0);
    check("lit_jam_clr_busy", busy, 1);
    wait_n(20);
    check("lit_jam_idle_busy", busy, 0);
    check("lit_jam_idle", last_idle_cyc - c0, 16);

    // second pulse inside holdoff is ignored
    i0 = ins_cnt; r0 = rej_cnt;
    pulse(20);
    wait_n(5);
    pulse(20); fall = cyc;
    wait_n(30);
    check("lit_holdoff_ins", ins_cnt - i0, 1);
    check("lit_holdoff_rej", rej_cnt - r0, 0);
    check("lit_holdoff_idle", last_idle_cyc - fall, 18);

    // reset during a pulse
    i0 = ins_cnt; r0 = rej_cnt;
    bill_raw = 1'b1;
    wait_n(10);
    rst = 1'b1;
    wait_n(5);
    rst = 1'b0;
    wait_n(15);
    check("lit_rstpulse_busy", busy, 1);
    bill_raw = 1'b0; fall = cyc;
    wait_n(30);
    check("lit_rstpulse_ins", ins_cnt - i0, 0);
    check("lit_rstpulse_rej", rej_cnt - r0, 0);
    check("lit_rstpulse_idle", last_idle_cyc - fall, 18);
    i0 = ins_cnt;
    pulse(20);
    wait_n(30);
    check("lit_after_rst_ins", ins_cnt - i0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bill_validator.md
# bill_validator

Front-end stage for `vending_machine`: conditions the raw bill-acceptor sensor into the single-cycle `insert_bill` strobe that the vending FSM counts. It synchronises the asynchronous sensor line and measures each high pulse's width in clock cycles. Valid-width pulses become exactly one `insert_bill`. Out-of-range pulses, pulses arriving while disabled, and stuck-high sensors become a reject indication instead. A low-time holdoff between bills and a sticky jam state protect the downstream counter from glitches and double counts.

## Interface
- `SYNC_STAGES`, 2: synchroniser flops on `bill_raw` (≥2)
- `MIN_W`, 8: minimum accepted pulse width, cycles
- `MAX_W`, 64: maximum accepted pulse width, cycles; width `MAX_W+1` means jam
- `GAP`, 16: consecutive low cycles required before the next bill is armed
- `CNT_W`, 8: counter width; must hold `max(MAX_W+1, GAP)`

- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `bill_raw`  in  1  raw sensor, asynchronous to `clk`, high while a bill passes
- `enable`  in  1  downstream can accept a bill (vending FSM idle)
- `jam_clr`  in  1  operator clear of jam; effective only in JAM
- `insert_bill`  out  1  one-cycle strobe per accepted bill, registered
- `reject`  out  1  one-cycle strobe per rejected or jammed pulse, registered
- `busy`  out  1  high in every state except IDLE, decoded from state
- `jam`  out  1  high while in JAM, registered

## Operation
- `s` is the last stage of the `SYNC_STAGES`-deep synchroniser. All FSM decisions use `s` only.
- The width counter `wcnt` and gap counter `gcnt` saturate and never wrap.
- FSM states: IDLE, MEASURE, HOLDOFF, JAM.
- IDLE: if `s`=1, then `wcnt`<=1 and go to MEASURE. Otherwise stay.
- MEASURE:
  - `s`=1 and `wcnt`<`MAX_W+1`: `wcnt`<=`wcnt`+1.
  - `s`=1 and `wcnt`==`MAX_W`: go to JAM; `reject`<=1 for one cycle; `jam`<=1.
  - `s`=0: width = `wcnt`.
    - If `MIN_W`≤width≤`MAX_W` and `enable`=1 at this same edge: `insert_bill`<=1.
    - Otherwise: `reject`<=1.
    - In both cases: `gcnt`<=0 and go to HOLDOFF.
- HOLDOFF:
  - `s`=1: `gcnt`<=0. The pulse is ignored, with no strobe and no measurement.
  - `s`=0: `gcnt`<=`gcnt`+1.
  - Go to IDLE at the edge where `gcnt` would reach `GAP`, i.e. after `GAP` consecutive low samples.
- JAM: hold. When `s`=0 and `jam_clr`=1 at the same edge: `jam`<=0, `gcnt`<=0, go to HOLDOFF. `jam_clr` is ignored in every other state.
- `insert_bill` and `reject` are never high in the same cycle. Each is high for exactly one cycle per event.

## Timing
- Reset values:
  - state = HOLDOFF, `gcnt`=0, `wcnt`=0, synchroniser flops 0.
  - `insert_bill`=0, `reject`=0, `jam`=0, `busy`=1.
- After reset, `GAP` low samples of `s` are required before the first bill is armed. A bill partially inserted when reset drops is therefore never counted.
- Reset asserted mid-pulse or mid-JAM: immediate return to the reset values. No strobe is emitted for the aborted pulse.
- Latency from a `bill_raw` falling edge to `insert_bill`/`reject`: `SYNC_STAGES`+1 clock edges.
- Measured width equals the `bill_raw` high time in cycles, ±1 for synchroniser phase.
- Jam detect: `reject` and `jam` rise `SYNC_STAGES`+`MAX_W`+1 edges after the `bill_raw` rising edge.
- Minimum bill-to-bill spacing: width + `GAP` + 1 cycles (+ synchroniser latency).
- `enable` is sampled only at the falling-edge decision edge. Changes of `enable` during MEASURE have no effect.

## Test plan
- Valid bill: defaults, `enable`=1, `bill_raw` high 20 cycles → `insert_bill` high exactly 1 cycle, 3 edges after the fall; `reject`=0; `busy` returns to 0 after 16 low cycles.
- Width bounds: pulses of 7, 8, 64 cycles (each separated by ≥20 low cycles) → `reject`, `insert_bill`, `insert_bill` respectively.
- Disabled: `enable`=0, 20-cycle pulse → `reject` 1 cycle, no `insert_bill`.
- Jam: `bill_raw` held high 100 cycles → `reject` and `jam` at edge 67 after the rise.
  - `jam_clr` pulsed while `bill_raw` is still high → `jam` stays 1.
  - `bill_raw` low, then `jam_clr` → `jam`=0, then IDLE after 16 low cycles.
- Holdoff: valid 20-cycle pulse, 5 low cycles, second 20-cycle pulse → exactly one `insert_bill`; IDLE reached only 16 cycles after the second pulse falls.
- Reset mid-pulse: assert `rst` at cycle 10 of a 30-cycle pulse, release at cycle 15 → no strobes. `busy`=1 until 16 low samples of `s` after the pulse ends; the next valid pulse is accepted.
